// File: rtl/rbm_main.sv
// rbm_main: stochastic Restricted Boltzmann Machine inference engine.
// A binary input image drives a stochastic hidden layer, whose samples
// drive a stochastic classifier layer; this repeats for iteration_num
// iterations. Per-class firing counts are the classification score.
// Optional build macro: SPARSE_EN narrows the input vector to
// sparse_input_dim and uses only the first weight rows.
module rbm_main #(
  parameter int    bitlength              = 16,
  parameter int    w_bitlength            = 12,
  parameter int    sigmoid_bitlength      = 8,
  parameter int    general_input_dim      = 784,
  parameter int    sparse_input_dim       = 64,
  parameter int    hidden_dim             = 441,
  parameter int    output_dim             = 10,
  parameter int    Inf                    = 'h7FF,
  parameter string h_weight_path          = "",
  parameter string h_bias_path            = "",
  parameter string h_seed_path            = "",
  parameter string h_ord_path             = "",
  parameter string c_weight_path          = "",
  parameter string c_bias_path            = "",
  parameter string c_seed_path            = "",
  parameter string c_ord_path             = "",
  parameter int    hidden_adder_group_num = 1,
  parameter int    cl_adder_group_num     = 1,
  parameter int    iteration_num          = 100
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            data_valid,
  input  logic [general_input_dim*hidden_dim*w_bitlength-1:0] HiddenWeightPort,
  input  logic [hidden_dim*w_bitlength-1:0]               HiddenBiasPort,
  input  logic [hidden_dim-1:0]                           HiddenSwitchPort,
  input  logic [hidden_dim*output_dim*w_bitlength-1:0]    ClassiWeightPort,
  input  logic [output_dim*w_bitlength-1:0]               ClassiBiasPort,
  input  logic [output_dim-1:0]                           ClassiSwitchPort,
`ifdef SPARSE_EN
  input  logic [sparse_input_dim-1:0]                     InputDataPort,
`else
  input  logic [general_input_dim-1:0]                    InputDataPort,
`endif
  output logic [output_dim*w_bitlength-1:0]               OutputDataPort,
  output logic                                            finish
);

`ifdef SPARSE_EN
  localparam int input_dim = sparse_input_dim;
`else
  localparam int input_dim = general_input_dim;
`endif

  localparam int NMAX = (hidden_dim > output_dim) ? hidden_dim : output_dim;
  localparam int NW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int IMAX = (input_dim > hidden_dim) ? input_dim : hidden_dim;
  localparam int IXW  = $clog2(IMAX + 1) + 1;
  localparam int IW   = $clog2(iteration_num + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HID  = 2'd1;
  localparam logic [1:0] CLS  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [w_bitlength-1:0] OUT_MAX = w_bitlength'(Inf);

  logic [1:0]                    state;
  logic                          smp;
  logic [IXW-1:0]                idx;
  logic [NW-1:0]                 nrn;
  logic [IW-1:0]                 iter;
  logic [15:0]                   lfsr;
  logic [hidden_dim-1:0]         hid_smp;
  logic [w_bitlength-1:0]        out_cnt [output_dim];
  logic signed [bitlength-1:0]   acc;
  logic signed [bitlength-1:0]   hid_sum;
  logic signed [bitlength-1:0]   cls_sum;
  logic                          hid_fire;
  logic                          cls_fire;
  logic [sigmoid_bitlength:0]    rnd;
  logic [sigmoid_bitlength:0]    prob;

  // Saturating signed add in the accumulator width.
  function automatic logic signed [bitlength-1:0] sat_add(
    input logic signed [bitlength-1:0] a,
    input logic signed [bitlength-1:0] b);
    logic signed [bitlength:0] s;
    s = {a[bitlength-1], a} + {b[bitlength-1], b};
    if (s[bitlength] != s[bitlength-1])
      sat_add = s[bitlength] ? {1'b1, {(bitlength-1){1'b0}}}
                             : {1'b0, {(bitlength-1){1'b1}}};
    else
      sat_add = s[bitlength-1:0];
  endfunction

  // Sign-extend a weight/bias word to the accumulator width.
  function automatic logic signed [bitlength-1:0] sext(
    input logic [w_bitlength-1:0] v);
    sext = {{(bitlength-w_bitlength){v[w_bitlength-1]}}, v};
  endfunction

  // Clamp to +/-Inf, then piecewise-linear sigmoid 128 + x/4 in [0,256].
  function automatic logic [sigmoid_bitlength:0] sigmoid(
    input logic signed [bitlength-1:0] a);
    int x;
    int p;
    x = int'(a);
    if (x > Inf)  x = Inf;
    if (x < -Inf) x = -Inf;
    p = 128 + (x >>> 2);
    if (p < 0)   p = 0;
    if (p > 256) p = 256;
    sigmoid = (sigmoid_bitlength+1)'(p);
  endfunction

  // Group sum for the current hidden neuron: bias on the first group,
  // then the weights of every active input in this group.
  always_comb begin
    int k;
    hid_sum = (idx == '0) ? sext(HiddenBiasPort[int'(nrn)*w_bitlength +: w_bitlength]) : acc;
    for (int g = 0; g < hidden_adder_group_num; g++) begin
      k = int'(idx) + g;
      if (k < input_dim) begin
        if (InputDataPort[k])
          hid_sum = sat_add(hid_sum,
            sext(HiddenWeightPort[(k*hidden_dim + int'(nrn))*w_bitlength +: w_bitlength]));
      end
    end
  end

  // Group sum for the current classifier neuron over the hidden samples.
  always_comb begin
    int k;
    cls_sum = (idx == '0) ? sext(ClassiBiasPort[int'(nrn)*w_bitlength +: w_bitlength]) : acc;
    for (int g = 0; g < cl_adder_group_num; g++) begin
      k = int'(idx) + g;
      if (k < hidden_dim) begin
        if (hid_smp[k])
          cls_sum = sat_add(cls_sum,
            sext(ClassiWeightPort[(k*output_dim + int'(nrn))*w_bitlength +: w_bitlength]));
      end
    end
  end

  // Stochastic firing decision against the LFSR low bits.
  always_comb begin
    rnd      = {1'b0, lfsr[sigmoid_bitlength-1:0]};
    prob     = sigmoid(acc);
    hid_fire = HiddenSwitchPort[nrn] && (rnd < prob);
    cls_fire = ClassiSwitchPort[nrn] && (rnd < prob);
  end

  // Accumulator: loaded on every accumulate cycle, idle otherwise.
  always_ff @(posedge clock) begin
    if (state == HID && !smp)
      acc <= hid_sum;
    else if (state == CLS && !smp)
      acc <= cls_sum;
  end

  // Control FSM, LFSR, hidden samples and class counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      finish  <= 1'b0;
      smp     <= 1'b0;
      idx     <= '0;
      nrn     <= '0;
      iter    <= '0;
      lfsr    <= 16'hACE1;
      hid_smp <= '0;
      for (int c = 0; c < output_dim; c++) out_cnt[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          finish <= 1'b0;
          if (data_valid) begin
            state <= HID;
            smp   <= 1'b0;
            idx   <= '0;
            nrn   <= '0;
            iter  <= '0;
            for (int c = 0; c < output_dim; c++) out_cnt[c] <= '0;
          end
        end
        HID: begin
          if (!smp) begin
            if (int'(idx) + hidden_adder_group_num >= input_dim) begin
              smp <= 1'b1;
              idx <= '0;
            end else begin
              idx <= idx + IXW'(hidden_adder_group_num);
            end
          end else begin
            smp          <= 1'b0;
            lfsr         <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            hid_smp[nrn] <= hid_fire;
            if (nrn == NW'(hidden_dim - 1)) begin
              nrn   <= '0;
              state <= CLS;
            end else begin
              nrn <= nrn + 1'b1;
            end
          end
        end
        CLS: begin
          if (!smp) begin
            if (int'(idx) + cl_adder_group_num >= hidden_dim) begin
              smp <= 1'b1;
              idx <= '0;
            end else begin
              idx <= idx + IXW'(cl_adder_group_num);
            end
          end else begin
            smp  <= 1'b0;
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (cls_fire && out_cnt[nrn] != OUT_MAX)
              out_cnt[nrn] <= out_cnt[nrn] + 1'b1;
            if (nrn == NW'(output_dim - 1)) begin
              nrn  <= '0;
              iter <= iter + 1'b1;
              if (iter == IW'(iteration_num - 1))
                state <= DONE;
              else
                state <= HID;
            end else begin
              nrn <= nrn + 1'b1;
            end
          end
        end
        default: begin
          finish <= 1'b1;
          if (!data_valid) begin
            state  <= IDLE;
            finish <= 1'b0;
          end
        end
      endcase
    end
  end

  // Flatten the class counters onto the output port.
  for (genvar c = 0; c < output_dim; c++) begin : g_out
    assign OutputDataPort[c*w_bitlength +: w_bitlength] = out_cnt[c];
  end

endmodule

// File: tb/tb_rbm_main.sv
// Directed bench for rbm_main with a 4-2-2 network, 4 iterations,
// instantiated twice: adder groups of 1 and adder groups of 2.
module tb_rbm_main;

  logic        clock = 1'b0;
  logic        reset;
  logic        data_valid;
  logic [95:0] hw;
  logic [23:0] hb;
  logic [1:0]  hs;
  logic [47:0] cw;
  logic [23:0] cb;
  logic [1:0]  cs;
  logic [3:0]  din;
  logic [23:0] out1, out2;
  logic        fin1, fin2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rbm_main #(.general_input_dim(4), .hidden_dim(2), .output_dim(2),
             .iteration_num(4), .hidden_adder_group_num(1),
             .cl_adder_group_num(1)) dut1 (
    .clock(clock), .reset(reset), .data_valid(data_valid),
    .HiddenWeightPort(hw), .HiddenBiasPort(hb), .HiddenSwitchPort(hs),
    .ClassiWeightPort(cw), .ClassiBiasPort(cb), .ClassiSwitchPort(cs),
    .InputDataPort(din), .OutputDataPort(out1), .finish(fin1));

  rbm_main #(.general_input_dim(4), .hidden_dim(2), .output_dim(2),
             .iteration_num(4), .hidden_adder_group_num(2),
             .cl_adder_group_num(2)) dut2 (
    .clock(clock), .reset(reset), .data_valid(data_valid),
    .HiddenWeightPort(hw), .HiddenBiasPort(hb), .HiddenSwitchPort(hs),
    .ClassiWeightPort(cw), .ClassiBiasPort(cb), .ClassiSwitchPort(cs),
    .InputDataPort(din), .OutputDataPort(out2), .finish(fin2));

  typedef struct {
    string       name;
    logic [11:0] hwv, hbv, cwv, cbv;
    logic [1:0]  hsv, csv;
    logic [3:0]  dinv;
    int          e0, e1;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    hw  = {8{v.hwv}};
    hb  = {2{v.hbv}};
    cw  = {4{v.cwv}};
    cb  = {2{v.cbv}};
    hs  = v.hsv;
    cs  = v.csv;
    din = v.dinv;
  endtask

  // Start a run, measure both latencies, check counts and the DONE handshake.
  task automatic run_vec(input vec_t v);
    int lat1, lat2;
    lat1 = 0;
    lat2 = 0;
    @(negedge clock);
    apply(v);
    data_valid = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 120; n++) begin
      @(posedge clock);
      #1;
      if (fin1 && lat1 == 0) lat1 = n;
      if (fin2 && lat2 == 0) lat2 = n;
      if (lat1 != 0 && lat2 != 0) break;
    end
    chk({v.name, " lat g1"}, lat1, 65);
    chk({v.name, " lat g2"}, lat2, 41);
    chk({v.name, " g1 out0"}, int'(out1[11:0]),  v.e0);
    chk({v.name, " g1 out1"}, int'(out1[23:12]), v.e1);
    chk({v.name, " g2 out0"}, int'(out2[11:0]),  v.e0);
    chk({v.name, " g2 out1"}, int'(out2[23:12]), v.e1);
    @(negedge clock);
    data_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk({v.name, " idle fin g1"}, int'(fin1), 0);
    chk({v.name, " idle fin g2"}, int'(fin2), 0);
    chk({v.name, " idle hold g1"}, int'(out1[11:0]), v.e0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"sat",      12'h7FF, 12'h000, 12'h7FF, 12'h000, 2'b11, 2'b11, 4'b1111, 4, 4};
    vecs[1] = '{"negfs",    12'h800, 12'h800, 12'h800, 12'h800, 2'b11, 2'b11, 4'b1111, 0, 0};
    vecs[2] = '{"csw01",    12'h7FF, 12'h000, 12'h7FF, 12'h000, 2'b11, 2'b01, 4'b1111, 4, 0};
    vecs[3] = '{"hsw0",     12'h7FF, 12'h000, 12'h7FF, 12'h7FF, 2'b00, 2'b11, 4'b1111, 4, 4};
    vecs[4] = '{"p256",     12'h7FF, 12'h000, 12'h7FF, 12'h200, 2'b00, 2'b11, 4'b1111, 4, 4};
    vecs[5] = '{"p0",       12'h7FF, 12'h000, 12'h7FF, 12'hE00, 2'b00, 2'b11, 4'b1111, 0, 0};
    vecs[6] = '{"in0001",   12'h7FF, 12'hE00, 12'h7FF, 12'hE00, 2'b11, 2'b11, 4'b0001, 4, 4};
    vecs[7] = '{"in0000",   12'h7FF, 12'hE00, 12'h7FF, 12'hE00, 2'b11, 2'b11, 4'b0000, 0, 0};

    apply(vecs[0]);
    reset      = 1'b0;
    data_valid = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst fin g1", int'(fin1), 0);
    chk("rst fin g2", int'(fin2), 0);
    chk("rst out g1", int'(out1), 0);
    chk("rst out g2", int'(out2), 0);
    data_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while DONE clears counts and finish without a clock edge.
    @(negedge clock);
    apply(vecs[0]);
    data_valid = 1'b1;
    repeat (70) @(negedge clock);
    chk("done fin", int'(fin1), 1);
    chk("done out0", int'(out1[11:0]), 4);
    #2;
    reset = 1'b0;
    #1;
    chk("async rst fin", int'(fin1), 0);
    chk("async rst out", int'(out1), 0);
    data_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Abort mid-HID, then restart with identical results.
    @(negedge clock);
    data_valid = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midhid fin", int'(fin1), 0);
    chk("midhid out", int'(out1), 0);
    data_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("midhid held fin", int'(fin1), 0);
    reset = 1'b1;
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rbm_main.md
Name: rbm_main

Overview:
- Stochastic Restricted Boltzmann Machine inference engine: binary input vector → stochastic binary hidden layer → stochastic classifier layer, repeated for iteration_num iterations.
- Per-class firing counts are accumulated and reported as the classification score.
- Top-level compute block; weights, biases and per-neuron enable switches arrive on flattened ports from the surrounding system.

Parameters:
- bitlength, 16: signed accumulator width.
- w_bitlength, 12: signed weight/bias/output width; fixed point, 256 = 1.0.
- sigmoid_bitlength, 8: probability/random compare width.
- general_input_dim, 784: input neurons, normal mode.
- sparse_input_dim, 64: input neurons with SPARSE_EN.
- hidden_dim, 441: hidden neurons.
- output_dim, 10: classifier neurons.
- Inf, 12'h7FF: positive saturation value; negative saturation is -Inf.
- h_weight_path, h_bias_path, h_seed_path, h_ord_path, c_weight_path, c_bias_path, c_seed_path, c_ord_path: strings, default "". Unused; kept only for positional parameter order.
- hidden_adder_group_num, 1: products summed per cycle, hidden layer.
- cl_adder_group_num, 1: products summed per cycle, classifier layer.
- iteration_num, 100: sampling iterations per image.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- data_valid, input, 1: level; starts inference when high in IDLE.
- HiddenWeightPort, input, general_input_dim*hidden_dim*w_bitlength: element (i,j) at flat index i*hidden_dim+j.
- HiddenBiasPort, input, hidden_dim*w_bitlength: hidden biases.
- HiddenSwitchPort, input, hidden_dim: hidden neuron enables.
- ClassiWeightPort, input, hidden_dim*output_dim*w_bitlength: element (i,j) at flat index i*output_dim+j.
- ClassiBiasPort, input, output_dim*w_bitlength: classifier biases.
- ClassiSwitchPort, input, output_dim: classifier neuron enables.
- InputDataPort, input, input_dim: binary image.
- OutputDataPort, output, output_dim*w_bitlength: per-class counts.
- finish, output, 1: result valid.

Behaviour:
- Flat packing: element k of width W occupies bits [(k+1)*W-1 : k*W].
- Reset (reset=0, asynchronous):
  - state=IDLE, finish=0, all OutputData=0, LFSR=16'hACE1, hidden sample register=0.
  - Mid-run reset aborts immediately.
- FSM states:
  - IDLE → HID when data_valid=1; clears counts and sets iter=0. Inputs are sampled live and must be held stable until finish.
  - HID: neurons j=0..hidden_dim-1 in order. For each neuron:
    - acc starts at sign-extended bias.
    - Each cycle adds weights of up to hidden_adder_group_num inputs whose bit=1; last group may be partial. This takes ceil(input_dim/G) cycles.
    - One more SAMPLE cycle follows.
  - CLS: same procedure over the hidden samples with ClassiWeight, ClassiBias and cl_adder_group_num.
  - After the last class: iter+1. If iter<iteration_num go to HID, else DONE.
  - DONE: finish=1 held. Return to IDLE (finish=0) only when data_valid=0.
- Arithmetic:
  - Every addition saturates to the signed bitlength range.
  - At SAMPLE, acc is clamped to [-Inf, Inf] giving x.
  - p = clamp(128 + (x>>>2), 0, 256), a piecewise-linear sigmoid.
  - Neuron fires iff switch=1 and LFSR[sigmoid_bitlength-1:0] < p. So p=256 always fires, p=0 never fires, switch=0 never fires.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances exactly once per SAMPLE cycle, including switched-off neurons. Not reset between images.
- Hidden samples from iteration t feed the classifier of iteration t only.
- Class k fires → OutputData[k]+1, saturating at Inf.
- Latency from data_valid accepted to finish=1:
  - iteration_num*(hidden_dim*(ceil(input_dim/Gh)+1) + output_dim*(ceil(hidden_dim/Gc)+1)) + 1 cycles.
- OutputData is stable while finish=1; holds its last value in IDLE until the next start.

Optional Feature:
- SPARSE_EN defined:
  - input_dim = sparse_input_dim; InputDataPort narrows to match.
  - Only weight rows 0..sparse_input_dim-1 are used; HiddenWeightPort keeps its full width.
- SPARSE_EN undefined: input_dim = general_input_dim.

Test Plan:
- Common setup: input_dim=4, hidden_dim=2, output_dim=2, iteration_num=4, groups=1.
- Reset low → finish=0, OutputData all 0; hold data_valid=1 during reset → no activity.
- Saturation: all inputs 1, all weights 12'h7FF, biases 0, switches 1 → finish after 4*(2*5+2*3)+1=65 cycles, OutputData={4,4}.
- All weights and biases 12'h800 (negative full scale) → OutputData={0,0}.
- ClassiSwitch=2'b01, positive weights → OutputData[0]=4, OutputData[1]=0. Then HiddenSwitch=0 with ClassiBias=12'h7FF → OutputData={4,4}.
- Pulse reset low mid-HID → finish=0, counts 0; restart completes in 65 cycles with identical results.
- Groups=2 → latency 4*(2*3+2*2)+1=41 cycles; results identical to groups=1 for the saturated cases.
